ddr_serializer: RTL

Parallel-to-serial stage that feeds a pair of `ddr_out` pads. Accepts W-bit words over a valid/ready handshake and emits two bits per `clk` as a (`d_rise`, `d_fall`) pair, sustaining two bits per clock with no gap between back-to-back words. A `frame` output marks cycles carrying valid data and drives a companion `ddr_out` as a data-enable or strobe line. Used for display and other DDR output links.

---
 rtl/ddr_serializer.sv | 74 +++++++
 1 files changed

// File: rtl/ddr_serializer.sv
// ddr_serializer: parallel-to-serial stage for a pair of DDR output pads.
// Takes W-bit words over valid/ready and sends two bits per clk as a
// (d_rise, d_fall) pair, with no gap between back-to-back words.
//
// Ports:
//   clk       clock
//   rst_n     async active-low reset
//   in_data   W-bit word, sampled only on accept (in_valid && in_ready)
//   in_valid  upstream word available
//   in_ready  block can take a word this cycle (decoded from state only)
//   d_rise    bit for the first half of the next pad cycle
//   d_fall    bit for the second half of that cycle
//   frame     high while d_rise/d_fall carry word data
module ddr_serializer #(
  parameter int W          = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         d_rise,
  output logic         d_fall,
  output logic         frame
);

  // Pair counter counts down the remaining pairs of the word on the pads.
  localparam int CW = (W > 2) ? $clog2(W/2) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W/2 - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sreg;
  logic           accept;
  logic           rise_bit, fall_bit;

  // Ready while idle or while the last pair of a word is showing, so the
  // next word lands on the edge that retires that pair (no bubble).
  assign in_ready = (state == IDLE) || (cnt == '0);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (accept) begin
      sreg  <= in_data;
      cnt   <= CNT_LAST;
      state <= SHIFT;
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        sreg <= MSB_FIRST ? (sreg << 2) : (sreg >> 2);
        cnt  <= cnt - 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Current pair sits at the outgoing end of the shift register.
  assign rise_bit = MSB_FIRST ? sreg[W-1] : sreg[0];
  assign fall_bit = MSB_FIRST ? sreg[W-2] : sreg[1];

  // Outputs decode registered state only; async reset forces idle at once.
  assign frame  = (state == SHIFT);
  assign d_rise = frame ? rise_bit : IDLE_LEVEL;
  assign d_fall = frame ? fall_bit : IDLE_LEVEL;

endmodule
